// File: rtl/spin_ctrl_pkg.sv
// Shared types for the spinning-disk controller slice.
// State encodings and per-revolution step count.
package spin_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SPIN_UP   = 2'd1,
    ST_SPIN      = 2'd2,
    ST_SPIN_DOWN = 2'd3
  } state_e;

  localparam int STEPS_PER_REV = 8;
  localparam logic [2:0] POS_LAST = 3'(STEPS_PER_REV - 1);

endpackage

// File: rtl/spin_ctrl_if.sv
// Button/estop inputs and run/step/state/div outputs of spin_ctrl.
// master = stimulus side, slave = controller side.
interface spin_ctrl_if
  import spin_ctrl_pkg::*;
#(
  parameter int DIV_W = 23
);

  logic             btn_n;
  logic             estop;
  logic             start;
  logic             step;
  state_e           state;
  logic [DIV_W-1:0] div;

  modport master (
    output btn_n, estop,
    input  start, step, state, div
  );

  modport slave (
    input  btn_n, estop,
    output start, step, state, div
  );

endinterface

// File: rtl/spin_ctrl_btn_debounce.sv
// Run/stop button synchroniser and debouncer.
// Emits a one-clk press pulse on an accepted 1->0 level change.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             acc_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == acc_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        cnt_q   <= '0;
        acc_q   <= sync2_q;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/spin_ctrl.sv
// Spinning-disk controller: run/stop FSM, step divider,
// position tracker and per-revolution speed ramp.
module spin_ctrl
  import spin_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int MAX_DIV    = 5000000,
  parameter int MIN_DIV    = 500000,
  parameter int DIV_STEP   = 500000
) (
  input  logic        clk,
  input  logic        rst,
  spin_ctrl_if.slave  bus
);

  localparam int DIV_W = $clog2(MAX_DIV + 1);
  localparam logic [DIV_W-1:0] MAXD = DIV_W'(MAX_DIV);
  localparam logic [DIV_W-1:0] MIND = DIV_W'(MIN_DIV);
  localparam logic [31:0] DN_LIM = 32'(MIN_DIV + DIV_STEP);

  logic             press;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [2:0]       pos_q, pos_d;
  logic             step_q, step_d;
  logic             start_q;
  logic             fire;
  logic             rev;
  logic [DIV_W-1:0] div_dn;
  logic [DIV_W-1:0] div_up;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (bus.btn_n),
    .press_o (press)
  );

  assign fire = (state_q != ST_IDLE)
             && (tick_q == div_q - 1'b1);
  assign rev  = fire && (pos_q == POS_LAST);

  // Ramps saturate at the speed limits, compared in 32 bits
  assign div_dn = (32'(div_q) < DN_LIM) ? MIND
                : div_q - DIV_W'(DIV_STEP);
  assign div_up =
    (32'(div_q) + 32'(DIV_STEP) >= 32'(MAX_DIV)) ? MAXD
    : div_q + DIV_W'(DIV_STEP);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = tick_q;
    pos_d   = pos_q;
    step_d  = 1'b0;
    if (state_q != ST_IDLE) begin
      step_d = fire;
      tick_d = fire ? '0 : tick_q + 1'b1;
      pos_d  = fire ? pos_q + 1'b1 : pos_q;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (press) state_d = ST_SPIN_UP;
      end
      ST_SPIN_UP: begin
        if (rev) begin
          div_d = div_dn;
          if (div_dn == MIND) state_d = ST_SPIN;
        end
        if (press) state_d = ST_SPIN_DOWN;
      end
      ST_SPIN: begin
        if (press) state_d = ST_SPIN_DOWN;
      end
      ST_SPIN_DOWN: begin
        if (rev) begin
          if (div_q == MAXD) begin
            state_d = ST_IDLE;
            pos_d   = '0;
          end else begin
            div_d = div_up;
          end
        end
        if (press) state_d = ST_SPIN_UP;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.estop) begin
      state_d = ST_IDLE;
      div_d   = MAXD;
      tick_d  = '0;
      pos_d   = '0;
      step_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      div_q   <= MAXD;
      tick_q  <= '0;
      pos_q   <= '0;
      step_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      start_q <= (state_d != ST_IDLE);
    end
  end

  assign bus.start = start_q;
  assign bus.step  = step_q;
  assign bus.state = state_q;
  assign bus.div   = div_q;

endmodule

// File: tb/tb_spin_ctrl.sv
// Directed bench for spin_ctrl with small ramp parameters.
// DEB_CYCLES=4 MAX_DIV=8 MIN_DIV=2 DIV_STEP=2.
module tb_spin_ctrl;
  import spin_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;
  int   nsteps;

  spin_ctrl_if #(.DIV_W(4)) bus ();

  spin_ctrl #(
    .DEB_CYCLES (4),
    .MAX_DIV    (8),
    .MIN_DIV    (2),
    .DIV_STEP   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial nsteps = 0;
  always @(posedge clk) begin
    if (bus.step === 1'b1) nsteps <= nsteps + 1;
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d, expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_btn(int n);
    bus.btn_n = 1'b0;
    cyc(n);
    bus.btn_n = 1'b1;
  endtask

  task automatic wait_state(state_e s, int bound,
                            string tag);
    int n = 0;
    while (bus.state !== s && n < bound) begin
      cyc(1);
      n++;
    end
    chk(tag, bus.state, s);
  endtask

  task automatic wait_step(int bound, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (bus.step !== 1'b1 && n < bound);
  endtask

  task automatic wait_div(int exp, int bound, string tag);
    int n = 0;
    while (bus.div !== 4'(exp) && n < bound) begin
      cyc(1);
      n++;
    end
    chk(tag, bus.div, exp);
    chk({tag, "_step"}, bus.step, 1);
  endtask

  initial begin
    int n;
    int n0;
    int exp_iv;
    vecs      = 0;
    errs      = 0;
    rst       = 1'b1;
    bus.btn_n = 1'b1;
    bus.estop = 1'b0;
    #2 rst = 1'b0;
    cyc(3);
    chk("rst_start", bus.start, 0);
    chk("rst_step",  bus.step,  0);
    chk("rst_state", bus.state, 0);
    chk("rst_div",   bus.div,   8);
    rst = 1'b1;
    cyc(20);
    chk("idle_nostep", nsteps, 0);
    chk("idle_state",  bus.state, 0);

    press_btn(3);
    cyc(15);
    chk("glitch_idle_state", bus.state, 0);

    // Spin-up ramp from rest
    fork press_btn(10); join_none
    wait_state(ST_SPIN_UP, 30, "up_state");
    chk("up_start", bus.start, 1);
    chk("up_div",   bus.div,   8);
    wait_step(20, n);
    chk("first_step_lat", n, 8);
    for (int i = 2; i <= 24; i++) begin
      exp_iv = (i <= 8) ? 8 : (i <= 16) ? 6 : 4;
      wait_step(20, n);
      chk($sformatf("iv_step%0d", i), n, exp_iv);
      if (i == 8)  chk("div_rev1", bus.div, 6);
      if (i == 16) chk("div_rev2", bus.div, 4);
    end
    chk("spin_state", bus.state, 2);
    chk("spin_div",   bus.div,   2);
    wait_step(20, n);
    chk("spin_iv_a", n, 2);
    wait_step(20, n);
    chk("spin_iv_b", n, 2);

    press_btn(3);
    cyc(20);
    chk("glitch_spin_state", bus.state, 2);
    chk("glitch_spin_div",   bus.div,   2);

    // Spin-down ramp back to rest
    fork press_btn(10); join_none
    wait_state(ST_SPIN_DOWN, 30, "down_state");
    chk("down_div", bus.div, 2);
    wait_div(4, 200, "down_div4");
    wait_div(6, 200, "down_div6");
    wait_div(8, 200, "down_div8");
    wait_state(ST_IDLE, 200, "down_idle");
    chk("down_idle_start", bus.start, 0);
    chk("down_idle_step",  bus.step,  1);
    chk("down_idle_div",   bus.div,   8);
    cyc(2);
    n0 = nsteps;
    cyc(20);
    chk("down_idle_quiet", nsteps, n0);

    // First rev after IDLE re-entry is 8 steps: pos realigned
    fork press_btn(10); join_none
    wait_state(ST_SPIN_UP, 30, "re_up_state");
    n0 = nsteps;
    wait_div(6, 200, "re_up_div6");
    chk("re_up_rev_steps", nsteps - n0 + 1, 8);
    cyc(3);
    bus.estop = 1'b1;
    cyc(1);
    bus.estop = 1'b0;
    chk("estop_state", bus.state, 0);
    chk("estop_start", bus.start, 0);
    chk("estop_div",   bus.div,   8);
    chk("estop_step",  bus.step,  0);
    n0 = nsteps;
    cyc(20);
    chk("estop_quiet", nsteps, n0);
    chk("estop_hold",  bus.state, 0);

    // estop in the same cycle the debounced press arrives
    fork press_btn(10); join_none
    wait_state(ST_SPIN_UP, 30, "co_up_state");
    cyc(20);
    bus.btn_n = 1'b0;
    cyc(6);
    chk("co_pre_state", bus.state, 1);
    bus.estop = 1'b1;
    cyc(1);
    bus.estop = 1'b0;
    chk("co_state", bus.state, 0);
    chk("co_start", bus.start, 0);
    chk("co_div",   bus.div,   8);
    chk("co_step",  bus.step,  0);
    cyc(4);
    bus.btn_n = 1'b1;
    cyc(15);
    chk("co_hold", bus.state, 0);

    // Async reset mid-SPIN between steps
    fork press_btn(10); join_none
    wait_state(ST_SPIN_UP, 30, "ar_up_state");
    wait_state(ST_SPIN, 300, "ar_spin_state");
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("ar_state", bus.state, 0);
    chk("ar_start", bus.start, 0);
    chk("ar_step",  bus.step,  0);
    chk("ar_div",   bus.div,   8);
    #2 rst = 1'b1;
    cyc(2);

    // Direction reversals mid-ramp
    fork press_btn(10); join_none
    wait_state(ST_SPIN_UP, 30, "rv_up_state");
    wait_div(6, 200, "rv_up_div6");
    wait_div(4, 200, "rv_up_div4");
    fork press_btn(10); join_none
    wait_state(ST_SPIN_DOWN, 30, "rv_down_state");
    chk("rv_down_div", bus.div, 4);
    wait_div(6, 200, "rv_down_div6");
    fork press_btn(10); join_none
    wait_state(ST_SPIN_UP, 30, "rv_reup_state");
    chk("rv_reup_div", bus.div, 6);
    wait_div(4, 200, "rv_reup_div4");
    chk("rv_reup_hold", bus.state, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
